act_pack_wb: RTL

- Sits directly downstream of the ReLU activation stage and consumes its activation stream (valid, last, 8-bit result).
- Packs consecutive activations into LANES-wide words and issues one registered write per full word to the output feature-map SRAM.
- The word address comes from an internal counter seeded from a per-job base address.
- The final partial word of a job is flushed with a byte strobe, and the job signals completion.

---
 rtl/act_pack_wb_pkg.sv | 15 +
 rtl/act_pack_wb_if.sv | 35 +++
 rtl/act_pack_wb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/act_pack_wb_pkg.sv
// Shared types and default sizing for the activation write-back packer.
// Imported by the packer interface and the packer itself.
package act_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_LANES           = 4;
  localparam int DEF_WORD_ADDR_WIDTH = 8;
  localparam int LANE_IDX_WIDTH      = $clog2(DEF_LANES);

endpackage

// File: rtl/act_pack_wb_if.sv
// Job control, activation stream and SRAM write port of the packer.
// The master side feeds jobs/activations; the slave side is the packer.
interface act_pack_wb_if
  import act_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LANES           = DEF_LANES,
  parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH
);

  logic                          start_i;
  logic [WORD_ADDR_WIDTH-1:0]    base_addr_i;
  logic                          act_valid_i;
  logic                          act_last_i;
  logic [DATA_WIDTH-1:0]         act_result_i;

  logic                          wr_en_o;
  logic [WORD_ADDR_WIDTH-1:0]    wr_addr_o;
  logic [DATA_WIDTH*LANES-1:0]   wr_data_o;
  logic [LANES-1:0]              wr_strb_o;
  logic                          done_o;
  logic                          busy_o;
  logic                          err_o;

  modport master (
    output start_i, base_addr_i, act_valid_i, act_last_i, act_result_i,
    input  wr_en_o, wr_addr_o, wr_data_o, wr_strb_o, done_o, busy_o, err_o
  );

  modport slave (
    input  start_i, base_addr_i, act_valid_i, act_last_i, act_result_i,
    output wr_en_o, wr_addr_o, wr_data_o, wr_strb_o, done_o, busy_o, err_o
  );

endinterface

// File: rtl/act_pack_wb.sv
// Packs ReLU activations into LANES-wide words and writes each word to the feature-map SRAM.
// One cycle from completing element to registered write; no backpressure, one element per cycle.
module act_pack_wb
  import act_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LANES           = DEF_LANES,
  parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  act_pack_wb_if.slave  bus
);

  localparam int LANE_W = $clog2(LANES);
  localparam int WORD_W = DATA_WIDTH * LANES;

  localparam logic [LANE_W-1:0]          LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0]          LANE_ONE  = LANE_W'(1);
  localparam logic [WORD_ADDR_WIDTH-1:0] ADDR_ONE  = WORD_ADDR_WIDTH'(1);

  state_t                       state_q, state_d;
  logic [LANE_W-1:0]            lane_q;
  logic [WORD_W-1:0]            asm_q, asm_next;
  logic [LANES-1:0]             strb_next;
  logic [WORD_ADDR_WIDTH-1:0]   addr_q;
  logic                         accept, word_done;

  logic                         wr_en_q;
  logic [WORD_ADDR_WIDTH-1:0]   wr_addr_q;
  logic [WORD_W-1:0]            wr_data_q;
  logic [LANES-1:0]             wr_strb_q;
  logic                         done_q;
  logic                         err_q;

  always_comb begin
    accept    = (state_q == RUN) && bus.act_valid_i;
    word_done = accept && ((lane_q == LAST_LANE) || bus.act_last_i);
  end

  // Word as it would look with the current element merged in; strobe covers lanes 0..lane_q.
  always_comb begin
    asm_next  = asm_q;
    strb_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        asm_next[i*DATA_WIDTH +: DATA_WIDTH] = bus.act_result_i;
      end
      strb_next[i] = (LANE_W'(i) <= lane_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = RUN;
      RUN:     if (accept && bus.act_last_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q    <= '0;
      asm_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q == IDLE) begin
        // A start in the same cycle as a stray element wins: the job begins with err clear.
        if (bus.start_i) begin
          addr_q <= bus.base_addr_i;
          lane_q <= '0;
          asm_q  <= '0;
          err_q  <= 1'b0;
        end else if (bus.act_valid_i) begin
          err_q <= 1'b1;
        end
      end else if (accept) begin
        if (word_done) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_q;
          wr_data_q <= asm_next;
          wr_strb_q <= strb_next;
          done_q    <= bus.act_last_i;
          addr_q    <= addr_q + ADDR_ONE;
          lane_q    <= '0;
          asm_q     <= '0;
        end else begin
          asm_q  <= asm_next;
          lane_q <= lane_q + LANE_ONE;
        end
      end
    end
  end

  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.wr_strb_o = wr_strb_q;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = (state_q == RUN);
  assign bus.err_o     = err_q;

endmodule
